hamming_rx_corrector: RTL and testbench
=======================================

// Module: hamming_rx_corrector
// PURPOSE
//  Serial SEC-DED receive end for the Hamming(16,11)+overall-parity link: accepts the encoder's
//  bit stream one bit per valid cycle, accumulates syndrome/parity on the fly, and corrects any
//  single-bit error. Flags double errors, then delivers the 11 data bits plus status.
//  Sits downstream of the encoder/decoder chain as the data-recovery sink.
// PARAMETERS
//  CNT_W   8   width of saturating statistics counters
// PORTS
//  clk            in   1      clock; all state on rising edge
//  rst            in   1      synchronous, active-high reset
//  din            in   1      serial codeword bit, index 0 first ... index 15 last
//  din_valid      in   1      din qualifier; one codeword bit per valid cycle
//  din_sof        in   1      with din_valid: this bit is index 0 (overall parity)
//  data_out       out  11     corrected data; [0]=pos3,[1]=pos5,[2]=pos6,[3]=pos7,[4]=pos9..[10]=pos15
//  data_valid     out  1      one-cycle pulse, data_out/status valid
//  err_corrected  out  1      single error fixed (qualified by data_valid)
//  err_double     out  1      uncorrectable double error (qualified by data_valid)
//  err_pos        out  4      flipped bit index when err_corrected, else 0
//  frame_err      out  1      one-cycle pulse: partial word dropped by early sof
//  busy           out  1      COLLECT state
//  cnt_words/cnt_corr/cnt_dbl  out  CNT_W  saturating counts of words/corrected/double
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, accumulators/bit counter cleared. Reset mid-word discards it.
//  - FSM IDLE: valid bits without sof ignored; valid+sof -> capture idx0, COLLECT, bitcnt=1.
//  - COLLECT: each valid bit stored at bitcnt, syn ^= bitcnt if din=1, par ^= din; bitcnt++.
//    On idx15: snapshot {word,syn,par} into stage-2 regs, bitcnt=0 -> IDLE.
//    din_valid=0 cycles hold state (no timeout).
//  - valid+sof while in COLLECT (bitcnt 1..15): drop partial, frame_err=1 next cycle,
//    restart with this bit as idx0 (accumulators reloaded, not XORed).
//  - Stage 2 (registered, latency 1): data_valid high the cycle after idx15 edge.
//      syn=0,par=0 -> clean; par=1 -> flip word[syn] (syn=0 = parity bit itself), err_corrected=1,
//      err_pos=syn; syn!=0,par=0 -> err_double=1, data_out = raw uncorrected extraction.
//  - Back-to-back: next word's sof may arrive in the same cycle as data_valid; no bubble needed.
//  - Counters increment on data_valid, saturate at all-ones, cleared only by rst.
//  - Status outputs held at last value between pulses; only qualified by data_valid.
// STRUCTURE
//  - hamming_pkg: HAM_N=16, HAM_K=11, HAM_SYN_W=4, data-position table DATA_POS[0:10],
//    status enum {CLEAN,CORRECTED,DOUBLE}; shared with encoder/decoder.
//  - Sub-module hamming_correct: combinational {word,syn,par} -> {data,status,err_pos};
//    top holds FSM, accumulators, stage-2 regs and counters.
// TESTING (codeword written idx15..idx0; data 0x34C encodes to 0x69C3)
//  1 clean: send 0x69C3, sof on idx0 -> 1 cycle after idx15: data_valid, data_out=0x34C, errs=0, err_pos=0
//  2 single: send 0x6DC3 (idx10 flipped) -> data_out=0x34C, err_corrected=1, err_pos=10
//  3 parity-bit error: send 0x69C2 -> data_out=0x34C, err_corrected=1, err_pos=0
//  4 double: send 0x69EB (idx3,idx5 flipped) -> err_double=1, err_corrected=0, data_out=0x34F
//  5 resync: 7 bits then sof + full 0x69C3 -> one frame_err pulse, exactly one data_valid, 0x34C
//  6 back-to-back x3 with gaps in din_valid, rst asserted mid 4th word -> 3 data_valid pulses,
//    cnt_words=3 before rst, all outputs/counters 0 after rst, no pulse for 4th word

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(16,11)+overall-parity SEC-DED link.
package hamming_pkg;

    localparam int unsigned HAM_N     = 16;
    localparam int unsigned HAM_K     = 11;
    localparam int unsigned HAM_SYN_W = 4;

    // Codeword index of each data bit; powers of two and index 0 carry parity.
    localparam logic [HAM_SYN_W-1:0] DATA_POS [HAM_K] = '{
        4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    typedef enum logic [1:0] {
        StatusClean,
        StatusCorrected,
        StatusDouble
    } ham_status_e;

    typedef struct packed {
        logic [HAM_N-1:0]     word;
        logic [HAM_SYN_W-1:0] syn;
        logic                 par;
    } ham_snap_t;

endpackage

// File: rtl/hamming_rx_corrector_if.sv
// Serial codeword input and corrected-data/status output bundle of the receive corrector.
interface hamming_rx_corrector_if
    import hamming_pkg::*;
#(
    parameter int unsigned CNT_W = 8
);
    logic                 din;
    logic                 din_valid;
    logic                 din_sof;
    logic [HAM_K-1:0]     data_out;
    logic                 data_valid;
    logic                 err_corrected;
    logic                 err_double;
    logic [HAM_SYN_W-1:0] err_pos;
    logic                 frame_err;
    logic                 busy;
    logic [CNT_W-1:0]     cnt_words;
    logic [CNT_W-1:0]     cnt_corr;
    logic [CNT_W-1:0]     cnt_dbl;

    modport master (
        output din, din_valid, din_sof,
        input  data_out, data_valid, err_corrected, err_double, err_pos,
        input  frame_err, busy, cnt_words, cnt_corr, cnt_dbl
    );

    modport slave (
        input  din, din_valid, din_sof,
        output data_out, data_valid, err_corrected, err_double, err_pos,
        output frame_err, busy, cnt_words, cnt_corr, cnt_dbl
    );
endinterface

// File: rtl/hamming_correct.sv
// Combinational SEC-DED decision: corrects a single flipped bit, flags double errors.
module hamming_correct
    import hamming_pkg::*;
(
    input  ham_snap_t             snap_i,
    output logic [HAM_K-1:0]      data_o,
    output ham_status_e           status_o,
    output logic [HAM_SYN_W-1:0]  err_pos_o
);
    logic [HAM_N-1:0] fixed;

    always_comb begin
        fixed     = snap_i.word;
        status_o  = StatusClean;
        err_pos_o = '0;
        // Odd overall parity means one flip; syndrome 0 points at the parity bit itself.
        if (snap_i.par) begin
            fixed[snap_i.syn] = ~snap_i.word[snap_i.syn];
            status_o          = StatusCorrected;
            err_pos_o         = snap_i.syn;
        end else if (snap_i.syn != '0) begin
            status_o = StatusDouble;
        end
        for (int i = 0; i < HAM_K; i++) begin
            data_o[i] = fixed[DATA_POS[i]];
        end
    end
endmodule

// File: rtl/hamming_rx_corrector.sv
// Serial SEC-DED receiver: accumulates syndrome/parity per bit, corrects on the following cycle.
module hamming_rx_corrector
    import hamming_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input logic                   clk,
    input logic                   rst,
    hamming_rx_corrector_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StCollect} state_e;

    state_e               state_q;
    logic [HAM_SYN_W-1:0] bitcnt_q;
    logic [HAM_N-1:0]     word_q, word_nxt;
    logic [HAM_SYN_W-1:0] syn_q, syn_nxt;
    logic                 par_q, par_nxt;
    ham_snap_t            snap_q;
    logic                 dv_q, fe_q;
    logic [CNT_W-1:0]     cnt_words_q, cnt_corr_q, cnt_dbl_q;

    logic [HAM_K-1:0]     data;
    ham_status_e          status;
    logic [HAM_SYN_W-1:0] err_pos;

    always_comb begin
        word_nxt           = word_q;
        word_nxt[bitcnt_q] = bus.din;
        syn_nxt            = syn_q ^ (bus.din ? bitcnt_q : '0);
        par_nxt            = par_q ^ bus.din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            bitcnt_q <= '0;
            word_q   <= '0;
            syn_q    <= '0;
            par_q    <= 1'b0;
            snap_q   <= '0;
            dv_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            fe_q <= 1'b0;
            if (bus.din_valid) begin
                if (bus.din_sof) begin
                    // A start bit mid-word abandons the partial word and reloads accumulators.
                    fe_q     <= (state_q == StCollect);
                    state_q  <= StCollect;
                    bitcnt_q <= 4'd1;
                    word_q   <= {{(HAM_N-1){1'b0}}, bus.din};
                    syn_q    <= '0;
                    par_q    <= bus.din;
                end else if (state_q == StCollect) begin
                    word_q   <= word_nxt;
                    syn_q    <= syn_nxt;
                    par_q    <= par_nxt;
                    bitcnt_q <= bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd15) begin
                        snap_q  <= {word_nxt, syn_nxt, par_nxt};
                        dv_q    <= 1'b1;
                        state_q <= StIdle;
                    end
                end
            end
        end
    end

    hamming_correct u_correct (
        .snap_i    (snap_q),
        .data_o    (data),
        .status_o  (status),
        .err_pos_o (err_pos)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_words_q <= '0;
            cnt_corr_q  <= '0;
            cnt_dbl_q   <= '0;
        end else if (dv_q) begin
            cnt_words_q <= cnt_words_q + {{(CNT_W-1){1'b0}}, ~&cnt_words_q};
            if (status == StatusCorrected) begin
                cnt_corr_q <= cnt_corr_q + {{(CNT_W-1){1'b0}}, ~&cnt_corr_q};
            end
            if (status == StatusDouble) begin
                cnt_dbl_q <= cnt_dbl_q + {{(CNT_W-1){1'b0}}, ~&cnt_dbl_q};
            end
        end
    end

    assign bus.data_out      = data;
    assign bus.data_valid    = dv_q;
    assign bus.err_corrected = (status == StatusCorrected);
    assign bus.err_double    = (status == StatusDouble);
    assign bus.err_pos       = err_pos;
    assign bus.frame_err     = fe_q;
    assign bus.busy          = (state_q == StCollect);
    assign bus.cnt_words     = cnt_words_q;
    assign bus.cnt_corr      = cnt_corr_q;
    assign bus.cnt_dbl       = cnt_dbl_q;
endmodule

// File: tb/tb_hamming_rx_corrector.sv
// Bench for hamming_rx_corrector: nearest-codeword reference model plus directed literal checks.
module tb_hamming_rx_corrector;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hamming_rx_corrector_if #(.CNT_W(8)) bus ();

    hamming_rx_corrector #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    localparam int POS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    typedef struct packed {
        logic [10:0] data;
        logic        corr;
        logic        dbl;
        logic [3:0]  pos;
    } res_t;

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] cw = '0;
        for (int i = 0; i < 11; i++) cw[POS[i]] = d[i];
        for (int k = 0; k < 4; k++) begin
            logic p = 1'b0;
            for (int j = 1; j < 16; j++) if (((j >> k) & 1) == 1 && j != (1 << k)) p ^= cw[j];
            cw[1 << k] = p;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    // Nearest valid codeword: distance 0 clean, 1 corrected, otherwise a raw double error.
    function automatic res_t decode(input logic [15:0] cw);
        res_t r = '0;
        for (int i = 0; i < 11; i++) r.data[i] = cw[POS[i]];
        r.dbl = 1'b1;
        for (int d = 0; d < 2048; d++) begin
            logic [15:0] diff = encode(d[10:0]) ^ cw;
            int n = $countones(diff);
            if (n <= 1) begin
                r.data = d[10:0];
                r.dbl  = 1'b0;
                r.corr = (n == 1);
                for (int b = 0; b < 16; b++) if (diff[b]) r.pos = b[3:0];
                return r;
            end
        end
        return r;
    endfunction

    // Reference model, advanced on every rising edge.
    bit          m_live = 0;
    int          m_cnt;
    logic [15:0] m_bits;
    logic        e_dv, e_fe, e_busy;
    res_t        e_res;
    int          e_words, e_corr, e_dbl;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1; m_cnt = 0; m_bits = '0;
            e_dv = 0; e_fe = 0; e_busy = 0; e_res = '0;
            e_words = 0; e_corr = 0; e_dbl = 0;
        end else if (m_live) begin
            if (e_dv) begin
                if (e_words < 255) e_words++;
                if (e_res.corr && e_corr < 255) e_corr++;
                if (e_res.dbl && e_dbl < 255) e_dbl++;
            end
            e_dv = 0;
            e_fe = 0;
            if (bus.din_valid) begin
                if (bus.din_sof) begin
                    e_fe      = (m_cnt != 0);
                    m_bits    = '0;
                    m_bits[0] = bus.din;
                    m_cnt     = 1;
                end else if (m_cnt != 0) begin
                    m_bits[m_cnt] = bus.din;
                    m_cnt++;
                    if (m_cnt == 16) begin
                        e_dv  = 1;
                        e_res = decode(m_bits);
                        m_cnt = 0;
                    end
                end
            end
            e_busy = (m_cnt != 0);
        end
    end

    int dv_seen = 0;
    int fe_seen = 0;

    always @(negedge clk) begin
        if (m_live) begin
            if (bus.data_valid === 1'b1) dv_seen++;
            if (bus.frame_err === 1'b1) fe_seen++;
            chk("data_valid", bus.data_valid, e_dv);
            chk("frame_err", bus.frame_err, e_fe);
            chk("busy", bus.busy, e_busy);
            chk("data_out", bus.data_out, e_res.data);
            chk("err_corrected", bus.err_corrected, e_res.corr);
            chk("err_double", bus.err_double, e_res.dbl);
            chk("err_pos", bus.err_pos, e_res.pos);
            chk("cnt_words", bus.cnt_words, e_words);
            chk("cnt_corr", bus.cnt_corr, e_corr);
            chk("cnt_dbl", bus.cnt_dbl, e_dbl);
        end
    end

    task automatic drive(input logic v, input logic d, input logic s);
        bus.din_valid = v;
        bus.din       = d;
        bus.din_sof   = s;
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [15:0] cw, input int nbits, input bit gaps);
        for (int i = 0; i < nbits; i++) begin
            if (gaps && i % 6 == 5) drive(1'b0, 1'b1, 1'b1);
            drive(1'b1, cw[i], i == 0);
        end
        bus.din_valid = 1'b0;
        bus.din_sof   = 1'b0;
    endtask

    task automatic expect_word(input string name, input logic [10:0] d, input logic c,
                               input logic db, input logic [3:0] p);
        chk({name, "_dv"}, bus.data_valid, 1'b1);
        chk({name, "_data"}, bus.data_out, d);
        chk({name, "_corr"}, bus.err_corrected, c);
        chk({name, "_dbl"}, bus.err_double, db);
        chk({name, "_pos"}, bus.err_pos, p);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    res_t r;
    int   dv0, fe0;

    initial begin
        bus.din = 1'b0; bus.din_valid = 1'b0; bus.din_sof = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        idle(1);

        chk("model_enc_34c", encode(11'h34C), 16'h69C3);
        r = decode(16'h6DC3);
        chk("model_dec_pos", r.pos, 4'd10);
        chk("model_dec_data", r.data, 11'h34C);
        chk("rst_data_out", bus.data_out, 11'h000);
        chk("rst_cnt_words", bus.cnt_words, 8'd0);

        send(16'h69C3, 16, 0); expect_word("clean", 11'h34C, 1'b0, 1'b0, 4'd0); idle(2);
        send(16'h6DC3, 16, 0); expect_word("single", 11'h34C, 1'b1, 1'b0, 4'd10); idle(2);
        send(16'h69C2, 16, 0); expect_word("parbit", 11'h34C, 1'b1, 1'b0, 4'd0); idle(2);
        send(16'h69EB, 16, 0); expect_word("double", 11'h34F, 1'b0, 1'b1, 4'd0); idle(2);

        dv0 = dv_seen; fe0 = fe_seen;
        send(16'h1234, 7, 0);
        send(16'h69C3, 16, 0); expect_word("resync", 11'h34C, 1'b0, 1'b0, 4'd0);
        idle(3);
        chk("resync_fe_pulses", fe_seen - fe0, 1);
        chk("resync_dv_pulses", dv_seen - dv0, 1);
        chk("stats_words", bus.cnt_words, 8'd5);
        chk("stats_corr", bus.cnt_corr, 8'd2);
        chk("stats_dbl", bus.cnt_dbl, 8'd1);

        rst = 1'b1; idle(1); rst = 1'b0;
        dv0 = dv_seen;
        send(16'h69C3, 16, 1); expect_word("b2b_0", 11'h34C, 1'b0, 1'b0, 4'd0);
        send(16'h6DC3, 16, 1); expect_word("b2b_1", 11'h34C, 1'b1, 1'b0, 4'd10);
        send(16'h69EB, 16, 1); expect_word("b2b_2", 11'h34F, 1'b0, 1'b1, 4'd0);
        send(16'h69C3, 9, 1);
        chk("b2b_busy", bus.busy, 1'b1);
        chk("b2b_words", bus.cnt_words, 8'd3);
        chk("b2b_corr", bus.cnt_corr, 8'd1);
        chk("b2b_dbl", bus.cnt_dbl, 8'd1);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        chk("post_rst_busy", bus.busy, 1'b0);
        chk("post_rst_dv", bus.data_valid, 1'b0);
        chk("post_rst_data", bus.data_out, 11'h000);
        chk("post_rst_errs", {bus.err_corrected, bus.err_double, bus.err_pos}, 6'd0);
        chk("post_rst_cnts", {bus.cnt_words, bus.cnt_corr, bus.cnt_dbl}, 24'd0);
        for (int i = 9; i < 16; i++) drive(1'b1, 1'b1, 1'b0);
        idle(3);
        chk("b2b_dv_pulses", dv_seen - dv0, 3);
        chk("tail_cnt_words", bus.cnt_words, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
